// File: rtl/safe_lock_controller_if.sv
// Keypad strobe and display/servo bundle of the safe lock controller.
// master = keypad/output side, slave = safe_lock_controller.
interface safe_lock_controller_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  state;
  logic [3:0]  chance_count;
  logic [15:0] input_data;
  logic [5:0]  timer_min;
  logic [5:0]  timer_sec;
  logic        door_open;

  modport master (
    output key_valid, key_code,
    input  state, chance_count, input_data, timer_min, timer_sec, door_open
  );

  modport slave (
    input  key_valid, key_code,
    output state, chance_count, input_data, timer_min, timer_sec, door_open
  );
endinterface

// File: rtl/safe_lock_controller.sv
// Digital safe sequencer: keypad entry, password check, retry budget, lockout and auto-relock timing.
// Optional password change via SET in OPEN is enabled by defining SAFE_PW_CHANGE_EN.
module safe_lock_controller #(
  parameter int PW_DIGITS = 4,
  parameter int MAX_CHANCE = 3,
  parameter int TICK_DIV = 50000000,
  parameter int OPEN_SEC = 10,
  parameter int FAIL_SEC = 2,
  parameter int LOCKOUT_SEC = 30,
  parameter logic [4*PW_DIGITS-1:0] DEFAULT_PW = 16'h1234
) (
  input logic clk,
  input logic rst,
  safe_lock_controller_if.slave bus
);

  localparam int DW = 4 * PW_DIGITS;
  localparam int CW = $clog2(PW_DIGITS + 1);
  localparam int PRW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRW-1:0] TICK_LAST = PRW'(TICK_DIV - 1);
  localparam logic [5:0] OPEN_MIN = 6'(OPEN_SEC / 60);
  localparam logic [5:0] OPEN_S = 6'(OPEN_SEC % 60);
  localparam logic [5:0] FAIL_MIN = 6'(FAIL_SEC / 60);
  localparam logic [5:0] FAIL_S = 6'(FAIL_SEC % 60);
  localparam logic [5:0] LOCK_MIN = 6'(LOCKOUT_SEC / 60);
  localparam logic [5:0] LOCK_S = 6'(LOCKOUT_SEC % 60);
  localparam logic [3:0] CHANCE_INIT = 4'(MAX_CHANCE);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INPUT   = 4'd1,
    ST_CHECK   = 4'd2,
    ST_OPEN    = 4'd3,
    ST_FAIL    = 4'd4,
    ST_LOCKOUT = 4'd5,
    ST_SET_PW  = 4'd6
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      chance_reg, chance_next;
  logic [DW-1:0]   data_reg, data_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [5:0]      min_reg, min_next;
  logic [5:0]      sec_reg, sec_next;
  logic [PRW-1:0]  presc_reg, presc_next;
  logic            door_reg, door_next;
  logic [DW-1:0]   pw_reg;

  logic key_digit, key_enter, key_clear, key_lock;
  assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_enter = bus.key_valid && (bus.key_code == 4'hA);
  assign key_clear = bus.key_valid && (bus.key_code == 4'hB);
  assign key_lock  = bus.key_valid && (bus.key_code == 4'hC);

`ifdef SAFE_PW_CHANGE_EN
  logic          key_set;
  logic [DW-1:0] pw_next;
  assign key_set = bus.key_valid && (bus.key_code == 4'hD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pw_reg <= DEFAULT_PW;
    else     pw_reg <= pw_next;
  end
`else
  assign pw_reg = DEFAULT_PW;
`endif

  logic [PW_DIGITS-1:0] digit_match;
  logic                 pw_match;
  genvar gi;
  generate
    for (gi = 0; gi < PW_DIGITS; gi++) begin : g_cmp
      assign digit_match[gi] = (data_reg[4*gi +: 4] == pw_reg[4*gi +: 4]);
    end
  endgenerate
  assign pw_match = &digit_match;

  // The tick that would take the timer to 00:00 is the one that ends the timed state.
  logic       tick, expire;
  logic [5:0] dec_min, dec_sec;
  assign tick   = (presc_reg == TICK_LAST);
  assign expire = tick && (min_reg == 6'd0) && (sec_reg <= 6'd1);

  always_comb begin
    dec_min = min_reg;
    dec_sec = sec_reg - 6'd1;
    if (sec_reg == 6'd0) begin
      dec_min = min_reg - 6'd1;
      dec_sec = 6'd59;
    end
  end

  logic       go_idle, run_timer, do_load;
  logic [5:0] load_min, load_sec;

  always_comb begin
    state_next  = state_reg;
    chance_next = chance_reg;
    data_next   = data_reg;
    count_next  = count_reg;
    min_next    = min_reg;
    sec_next    = sec_reg;
    presc_next  = presc_reg;
    go_idle     = 1'b0;
    run_timer   = 1'b0;
    do_load     = 1'b0;
    load_min    = 6'd0;
    load_sec    = 6'd0;
`ifdef SAFE_PW_CHANGE_EN
    pw_next     = pw_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (key_digit) begin
          state_next = ST_INPUT;
          data_next  = {{(DW-4){1'b0}}, bus.key_code};
          count_next = CW'(1);
        end
      end
      ST_INPUT: begin
        if (key_digit && (count_reg < CW'(PW_DIGITS))) begin
          data_next  = {data_reg[DW-5:0], bus.key_code};
          count_next = count_reg + CW'(1);
        end else if (key_clear) begin
          data_next  = '0;
          count_next = '0;
        end else if (key_enter && (count_reg == CW'(PW_DIGITS))) begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        do_load = 1'b1;
        if (pw_match) begin
          state_next  = ST_OPEN;
          chance_next = CHANCE_INIT;
          load_min    = OPEN_MIN;
          load_sec    = OPEN_S;
        end else if (chance_reg > 4'd1) begin
          state_next  = ST_FAIL;
          chance_next = chance_reg - 4'd1;
          load_min    = FAIL_MIN;
          load_sec    = FAIL_S;
        end else begin
          state_next  = ST_LOCKOUT;
          chance_next = 4'd0;
          load_min    = LOCK_MIN;
          load_sec    = LOCK_S;
        end
      end
      ST_OPEN: begin
        if (expire || key_lock) begin
          go_idle = 1'b1;
`ifdef SAFE_PW_CHANGE_EN
        end else if (key_set) begin
          state_next = ST_SET_PW;
          data_next  = '0;
          count_next = '0;
`endif
        end else begin
          run_timer = 1'b1;
        end
      end
      ST_FAIL: begin
        if (expire) go_idle = 1'b1;
        else        run_timer = 1'b1;
      end
      ST_LOCKOUT: begin
        if (expire) begin
          go_idle     = 1'b1;
          chance_next = CHANCE_INIT;
        end else begin
          run_timer = 1'b1;
        end
      end
`ifdef SAFE_PW_CHANGE_EN
      ST_SET_PW: begin
        if (key_digit && (count_reg < CW'(PW_DIGITS))) begin
          data_next  = {data_reg[DW-5:0], bus.key_code};
          count_next = count_reg + CW'(1);
        end else if (key_clear) begin
          data_next  = '0;
          count_next = '0;
        end else if ((key_enter && (count_reg == CW'(PW_DIGITS))) || key_lock) begin
          if (key_enter) pw_next = data_reg;
          state_next = ST_OPEN;
          do_load    = 1'b1;
          load_min   = OPEN_MIN;
          load_sec   = OPEN_S;
        end
      end
`endif
      default: go_idle = 1'b1;
    endcase

    if (run_timer) begin
      if (tick) begin
        presc_next = '0;
        min_next   = dec_min;
        sec_next   = dec_sec;
      end else begin
        presc_next = presc_reg + PRW'(1);
      end
    end
    if (do_load) begin
      presc_next = '0;
      min_next   = load_min;
      sec_next   = load_sec;
    end
    // Every return to IDLE leaves a blank buffer and a stopped 00:00 timer.
    if (go_idle) begin
      state_next = ST_IDLE;
      data_next  = '0;
      count_next = '0;
      min_next   = 6'd0;
      sec_next   = 6'd0;
      presc_next = '0;
    end
    door_next = (state_next == ST_OPEN) || (state_next == ST_SET_PW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      chance_reg <= CHANCE_INIT;
      data_reg   <= '0;
      count_reg  <= '0;
      min_reg    <= 6'd0;
      sec_reg    <= 6'd0;
      presc_reg  <= '0;
      door_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      chance_reg <= chance_next;
      data_reg   <= data_next;
      count_reg  <= count_next;
      min_reg    <= min_next;
      sec_reg    <= sec_next;
      presc_reg  <= presc_next;
      door_reg   <= door_next;
    end
  end

  assign bus.state        = state_reg;
  assign bus.chance_count = chance_reg;
  assign bus.input_data   = data_reg;
  assign bus.timer_min    = min_reg;
  assign bus.timer_sec    = sec_reg;
  assign bus.door_open    = door_reg;

endmodule
